// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC arctangent scheduler.
package cordic_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int CYCLES_DEF     = 3;
    localparam int ITER_CYCLES    = 2 ** CYCLES_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/cordic_atan_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or
// after the pointer, wrapping around modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_valid
);

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        int j;
        j         = 0;
        grant     = {NUM_REQ{1'b0}};
        idx       = {ID_W{1'b0}};
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any_valid && valid[j]) begin
                grant[j]  = 1'b1;
                idx       = ID_W'(j);
                any_valid = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/cordic_atan_sched.sv
// Shares one external iterative CORDIC arctangent engine among NUM_REQ
// requesters: round-robin accept, start pulse, fixed iteration wait, then a
// valid/ready result carrying the owning requester's ID.
module cordic_atan_sched
    import cordic_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int CYCLES     = CYCLES_DEF,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_x,
    output logic [DATA_WIDTH-1:0]         eng_y,
    input  logic [DATA_WIDTH-1:0]         eng_z,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH-1:0]         res_atan,
    output logic [ID_W-1:0]               res_id
);

    localparam logic [CYCLES-1:0] CNT_LAST = {CYCLES{1'b1}};

    sched_state_e            state_r;
    logic [ID_W-1:0]         rr_ptr_r;
    logic [ID_W-1:0]         gid_r;
    logic [CYCLES-1:0]       cnt_r;
    logic                    armed_r;
    logic                    eng_start_r;
    logic [DATA_WIDTH-1:0]   eng_x_r;
    logic [DATA_WIDTH-1:0]   eng_y_r;
    logic                    res_valid_r;
    logic [DATA_WIDTH-1:0]   res_atan_r;
    logic [ID_W-1:0]         res_id_r;

    logic [NUM_REQ-1:0]      grant_s;
    logic [ID_W-1:0]         grant_idx_s;
    logic                    any_valid_s;
    logic                    offer_s;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   sel_x_s;
    logic [DATA_WIDTH-1:0]   sel_y_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .idx       (grant_idx_s),
        .any_valid (any_valid_s)
    );

    // Grants are offered only in IDLE, and never while reset is still
    // settling (armed_r keeps req_ready low during and just after reset).
    always_comb begin
        offer_s   = armed_r && (state_r == IDLE);
        accept_s  = offer_s && any_valid_s;
        sel_x_s   = req_x[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
        sel_y_s   = req_y[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
        if (offer_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Scheduler FSM plus all registered engine/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {ID_W{1'b0}};
            gid_r       <= {ID_W{1'b0}};
            cnt_r       <= {CYCLES{1'b0}};
            armed_r     <= 1'b0;
            eng_start_r <= 1'b0;
            eng_x_r     <= {DATA_WIDTH{1'b0}};
            eng_y_r     <= {DATA_WIDTH{1'b0}};
            res_valid_r <= 1'b0;
            res_atan_r  <= {DATA_WIDTH{1'b0}};
            res_id_r    <= {ID_W{1'b0}};
        end else begin
            armed_r     <= 1'b1;
            eng_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        eng_x_r     <= sel_x_s;
                        eng_y_r     <= sel_y_s;
                        gid_r       <= grant_idx_s;
                        eng_start_r <= 1'b1;
                        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
                            rr_ptr_r <= {ID_W{1'b0}};
                        end else begin
                            rr_ptr_r <= grant_idx_s + ID_W'(1);
                        end
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    // eng_start is high for this whole cycle.
                    cnt_r   <= {CYCLES{1'b0}};
                    state_r <= RUN;
                end
                RUN: begin
                    cnt_r <= cnt_r + CYCLES'(1);
                    if (cnt_r == CNT_LAST) begin
                        res_atan_r  <= eng_z;
                        res_id_r    <= gid_r;
                        res_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign eng_start = eng_start_r;
    assign eng_x     = eng_x_r;
    assign eng_y     = eng_y_r;
    assign res_valid = res_valid_r;
    assign res_atan  = res_atan_r;
    assign res_id    = res_id_r;

endmodule

// File: tb/tb_cordic_atan_sched.sv
// Directed self-checking bench for cordic_atan_sched with a stub engine that
// returns eng_x + eng_y a fixed number of cycles after eng_start.
`timescale 1ns/1ps
module tb_cordic_atan_sched;

    localparam int DW   = 16;
    localparam int CYC  = 3;
    localparam int NR   = 4;
    localparam int IW   = 2;
    localparam int ITER = 2 ** CYC;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_x;
    logic [NR*DW-1:0] req_y;
    logic            eng_start;
    logic [DW-1:0]   eng_x, eng_y, eng_z;
    logic            res_valid, res_ready;
    logic [DW-1:0]   res_atan;
    logic [IW-1:0]   res_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cnt = 0;
    int grant_q[$];
    int grant_cyc_q[$];
    int res_id_q[$];
    int res_atan_q[$];
    int res_cyc_q[$];
    logic [3:0] stub_cnt;

    cordic_atan_sched #(.DATA_WIDTH(DW), .CYCLES(CYC), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_atan(res_atan), .res_id(res_id)
    );

    always #5 clk = ~clk;

    // Stub engine: result appears before the scheduler's capture edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 4'd0;
            eng_z    <= 16'h0000;
        end else if (eng_start) begin
            stub_cnt <= 4'(ITER - 1);
            eng_z    <= 16'hDEAD;
        end else if (stub_cnt == 4'd1) begin
            stub_cnt <= 4'd0;
            eng_z    <= eng_x + eng_y;
        end else if (stub_cnt != 4'd0) begin
            stub_cnt <= stub_cnt - 4'd1;
        end
    end

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: record grants, result handshakes and start pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (|(req_valid & req_ready)) begin
                grant_q.push_back(onehot_idx(req_valid & req_ready));
                grant_cyc_q.push_back(cyc);
            end
            if (res_valid && res_ready) begin
                res_id_q.push_back(int'(res_id));
                res_atan_q.push_back(int'(res_atan));
                res_cyc_q.push_back(cyc);
            end
            if (eng_start) start_cnt <= start_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
        req_x[i*DW +: DW] = x;
        req_y[i*DW +: DW] = y;
    endtask

    task automatic clear_q();
        grant_q.delete(); grant_cyc_q.delete();
        res_id_q.delete(); res_atan_q.delete(); res_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 4'b0000; res_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        clear_q();
    endtask

    task automatic wait_res(input int max, output int n);
        n = 0;
        while (!res_valid && n < max) begin tick(); n++; end
    endtask

    task automatic wait_nres(input int want, input int max);
        int n;
        n = 0;
        while (res_id_q.size() < want && n < max) begin tick(); n++; end
    endtask

    // Expected data for test 2/3: x = {0010,1010,2010,3010}, y = {1,2,3,4}.
    logic [15:0] t2_x   [4] = '{16'h0010, 16'h1010, 16'h2010, 16'h3010};
    logic [15:0] t2_y   [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] t2_sum [4] = '{16'h0011, 16'h1012, 16'h2013, 16'h3014};

    initial begin
        int n;
        logic [15:0] hold_atan;
        logic [IW-1:0] hold_id;
        bit stable, rdy_seen;
        int s0;

        req_x = '0; req_y = '0; req_valid = 4'b0000; res_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        // Reset values while rst_n is low, with a request pending.
        req_valid = 4'b0001; #1;
        check_eq("rst_req_ready", req_ready, 4'b0000);
        check_eq("rst_eng_start", eng_start, 1'b0);
        check_eq("rst_eng_x", eng_x, 16'h0000);
        check_eq("rst_eng_y", eng_y, 16'h0000);
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_atan", res_atan, 16'h0000);
        check_eq("rst_res_id", res_id, 2'd0);
        req_valid = 4'b0000;
        rst_n = 1'b1; tick(); tick(); clear_q();

        // 1. Single request on requester 0.
        set_req(0, 16'h0100, 16'h0200);
        res_ready = 1'b1; req_valid = 4'b0001; #1;
        check_eq("t1_req_ready", req_ready, 4'b0001);
        s0 = start_cnt;
        tick();                                   // accept edge T
        check_eq("t1_eng_start", eng_start, 1'b1);
        check_eq("t1_eng_x", eng_x, 16'h0100);
        check_eq("t1_eng_y", eng_y, 16'h0200);
        check_eq("t1_ready_load", req_ready, 4'b0000);
        req_valid = 4'b0000;
        wait_res(40, n);
        // res_valid rises at edge T+9, so the first edge that samples it is T+10.
        check_eq("t1_latency", n, 32'd9);
        check_eq("t1_res_atan", res_atan, 16'h0300);
        check_eq("t1_res_id", res_id, 2'd0);
        tick();
        check_eq("t1_res_cleared", res_valid, 1'b0);
        check_eq("t1_starts", start_cnt - s0, 32'd1);

        // 2. All four requesting from rr_ptr=0: grants 0,1,2,3,0, 11 cycles apart.
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, t2_x[i], t2_y[i]);
        res_ready = 1'b1; req_valid = 4'b1111;
        n = 0;
        while (grant_q.size() < 5 && n < 100) begin tick(); n++; end
        check_eq("t2_got5", grant_q.size() >= 5, 1'b1);
        if (grant_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_eq($sformatf("t2_grant%0d", i), grant_q[i], i % 4);
            for (int i = 1; i < 5; i++)
                check_eq($sformatf("t2_gap%0d", i), grant_cyc_q[i] - grant_cyc_q[i-1], 32'd11);
        end
        check_eq("t2_got4res", res_id_q.size() >= 4, 1'b1);
        if (res_id_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("t2_res_id%0d", i), res_id_q[i], i);
                check_eq($sformatf("t2_res_atan%0d", i), res_atan_q[i], t2_sum[i]);
            end
        end

        // 3. Back-pressure for 20 cycles, requests still pending.
        res_ready = 1'b0;
        wait_res(40, n);
        check_eq("t3_res_valid", res_valid, 1'b1);
        hold_atan = res_atan; hold_id = res_id;
        s0 = start_cnt; stable = 1'b1; rdy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_atan !== hold_atan || res_id !== hold_id || res_valid !== 1'b1) stable = 1'b0;
            if (req_ready != 4'b0000) rdy_seen = 1'b1;
        end
        check_eq("t3_stable", stable, 1'b1);
        check_eq("t3_no_ready", rdy_seen, 1'b0);
        check_eq("t3_no_start", start_cnt - s0, 32'd0);
        check_eq("t3_atan_match_id", hold_atan, t2_sum[hold_id]);
        clear_q();
        res_ready = 1'b1;
        n = 0;
        while (grant_q.size() < 1 && n < 10) begin tick(); n++; end
        check_eq("t3_hs_and_grant", (grant_q.size() >= 1) && (res_cyc_q.size() >= 1), 1'b1);
        if (grant_q.size() >= 1 && res_cyc_q.size() >= 1)
            check_eq("t3_grant_next_cycle", grant_cyc_q[0] - res_cyc_q[0], 32'd1);

        // 4. Wrap and skip: rr_ptr=3 with valid=0110 grants 1, then rr_ptr=2.
        do_reset();
        set_req(1, 16'h0005, 16'h0006);
        set_req(2, 16'h0007, 16'h0008);
        res_ready = 1'b1; req_valid = 4'b0100;
        tick(); req_valid = 4'b0000;
        wait_nres(1, 40);
        req_valid = 4'b0110; #1;
        check_eq("t4_wrap_ready", req_ready, 4'b0010);
        tick(); req_valid = 4'b0000;
        check_eq("t4_eng_x", eng_x, 16'h0005);
        wait_nres(2, 40);
        req_valid = 4'b0110; #1;
        check_eq("t4_ptr2_ready", req_ready, 4'b0100);
        req_valid = 4'b0000;

        // 5. Reset during RUN cycle 5, requester 1 pending.
        do_reset();
        set_req(0, 16'h1111, 16'h2222);
        set_req(1, 16'h0040, 16'h0002);
        res_ready = 1'b1; req_valid = 4'b0001;
        tick();                                   // accept, LOAD
        req_valid = 4'b0010;
        tick();                                   // RUN cycle 0
        for (int i = 0; i < 5; i++) tick();       // RUN cycle 5
        rst_n = 1'b0; #1;
        check_eq("t5_res_valid", res_valid, 1'b0);
        check_eq("t5_req_ready", req_ready, 4'b0000);
        check_eq("t5_eng_x", eng_x, 16'h0000);
        tick(); clear_q();
        rst_n = 1'b1;
        n = 0;
        while (n < 40) begin
            tick(); n++;
            if (grant_q.size() > 0) req_valid = 4'b0000;
        end
        check_eq("t5_one_grant", grant_q.size(), 32'd1);
        check_eq("t5_one_result", res_id_q.size(), 32'd1);
        if (res_id_q.size() == 1) begin
            check_eq("t5_res_id", res_id_q[0], 32'd1);
            check_eq("t5_res_atan", res_atan_q[0], 32'h0042);
        end

        // 6. Extreme data on requester 3.
        do_reset();
        set_req(3, 16'h8000, 16'h7FFF);
        res_ready = 1'b1; req_valid = 4'b1000;
        n = 0;
        while (!eng_start && n < 10) begin tick(); n++; end
        req_valid = 4'b0000;
        check_eq("t6_start", eng_start, 1'b1);
        check_eq("t6_eng_x", eng_x, 16'h8000);
        check_eq("t6_eng_y", eng_y, 16'h7FFF);
        wait_res(40, n);
        check_eq("t6_res_valid", res_valid, 1'b1);
        check_eq("t6_res_atan", res_atan, 16'hFFFF);
        check_eq("t6_res_id", res_id, 2'd3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_atan_sched.md
Name: cordic_atan_sched

Overview:
Round-robin scheduler that shares one iterative CORDIC arctangent engine among NUM_REQ requesters.
- Arbitrates coordinate requests and loads the winner's x/y into the engine.
- Pulses the engine start, counts the 2**CYCLES iteration cycles, then captures the angle.
- Returns the angle with the requester ID over a valid/ready result port.
- Sits between client blocks and the single engine instance; the engine itself is external.

Parameters:
DATA_WIDTH, 16, width of x, y and angle (signed two's complement)
CYCLES, 3, engine runs 2**CYCLES iteration cycles per operation
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid, one bit per requester
req_ready  out  NUM_REQ  one-hot grant/accept
req_x  in  NUM_REQ*DATA_WIDTH  packed signed x; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_y  in  NUM_REQ*DATA_WIDTH  packed signed y, same packing
eng_start  out  1  one-cycle pulse; engine loads eng_x/eng_y
eng_x  out  DATA_WIDTH  registered x to engine
eng_y  out  DATA_WIDTH  registered y to engine
eng_z  in  DATA_WIDTH  engine angle output
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_atan  out  DATA_WIDTH  captured angle
res_id  out  ID_W  index of requester that owns res_atan

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE. Reset enters IDLE.
- Reset values: req_ready=0, eng_start=0, eng_x=0, eng_y=0, res_valid=0, res_atan=0, res_id=0, rr_ptr=0, iteration counter=0.
- IDLE:
  - req_ready is combinational: one-hot on the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is 0 in every other state.
  - Handshake fires when req_valid[g]&req_ready[g]. On that edge: latch req_x[g], req_y[g] into eng_x/eng_y; latch g into grant ID; set rr_ptr=(g+1) mod NUM_REQ; go to LOAD.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- LOAD: eng_start=1 for exactly this cycle; clear counter; go to RUN.
- RUN:
  - Counter increments each cycle.
  - When counter==2**CYCLES-1: register eng_z into res_atan, grant ID into res_id, set res_valid=1, go to DONE.
  - RUN lasts exactly 2**CYCLES cycles.
- DONE: hold res_valid, res_atan and res_id stable until res_valid&res_ready. On that edge clear res_valid and go to IDLE. A new grant is possible the following cycle.
- Latency: accept edge to first res_valid cycle = 2**CYCLES+2 cycles (10 at default).
- Throughput: one operation per 2**CYCLES+3 cycles when res_ready=1.
- Back-pressure: res_ready low stalls in DONE. No new request is accepted, and the engine receives no start.
- eng_x/eng_y hold their values from the accept edge until the next accept.
- Requester dropping req_valid before grant: no effect, no request lost.
- Counter width is CYCLES bits; wrap-around from 2**CYCLES-1 to 0 is never reached inside RUN.
- Reset asserted mid-operation: immediate abort, all outputs to reset values, in-flight result discarded, no output on release.
- No arithmetic on data; values pass through unmodified, including 0x8000 and x=y=0.

Decomposition:
- Package cordic_pkg holds:
  - state enum typedef sched_state_e {IDLE, LOAD, RUN, DONE};
  - shared DATA_WIDTH/CYCLES defaults;
  - localparam ITER_CYCLES = 2**CYCLES.
- One sub-module: rr_arbiter (NUM_REQ). Inputs: valid vector, pointer. Outputs: one-hot grant, binary index, any_valid. Purely combinational.

Test Plan:
Bench uses a stub engine: 2**CYCLES cycles after eng_start it drives eng_z = eng_x + eng_y.
1. Single request: req_valid=0001, x=0x0100, y=0x0200, res_ready=1 -> accept at T, eng_start at T+1, res_valid at T+10, res_atan=0x0300, res_id=0.
2. Simultaneous requests: all four req_valid held high, rr_ptr=0 -> grants in order 0,1,2,3,0; each grant starts 11 cycles after the previous.
3. Back-pressure: res_ready=0 for 20 cycles after res_valid -> res_atan/res_id stable, req_ready stays 0, no eng_start pulse. Raise res_ready -> handshake, then the next grant one cycle later.
4. Wrap and skip: rr_ptr=3, req_valid=0110 -> grant requester 1, then rr_ptr=2.
5. Reset mid-RUN: assert rst_n=0 at cycle 5 of RUN -> res_valid=0, req_ready=0 and state IDLE immediately; no result after release; a pending request is then granted normally.
6. Extreme data: x=0x8000, y=0x7FFF on requester 3 -> eng_x=0x8000, eng_y=0x7FFF exactly; res_atan=0xFFFF; res_id=3.
